// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, FSM encoding and counter helper.
// Used by the capture block and the transmitter.
package vga_pkg;

  localparam int H_TOTAL_DEF    = 800;
  localparam int V_TOTAL_DEF    = 521;
  localparam int H_SYNC_LEN_DEF = 96;
  localparam int V_SYNC_LEN_DEF = 2;
  localparam int WIN_X0_DEF     = 336;
  localparam int WIN_Y0_DEF     = 143;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } vga_state_t;

  function automatic logic [9:0] sat_inc(
    input logic [9:0] v
  );
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_meter.sv
// Sync leading-edge detector with pulse-width measurement.
// width holds the length of the latest pulse, in ticks.
module vga_sync_meter
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tick,
  input  logic       sync,
  output logic       rise,
  output logic [9:0] width
);

  logic       prev;
  logic [9:0] cnt;

  assign rise  = en && sync && !prev;
  assign width = cnt;

  // At a leading edge width still shows the previous pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else if (en) begin
      prev <= sync;
      if (rise)
        cnt <= {9'd0, tick};
      else if (sync && tick)
        cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/vga_capture.sv
// VGA stream capture: sync lock FSM and windowed
// writes into a 256x256 video RAM.
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_TOTAL    = H_TOTAL_DEF,
  parameter int V_TOTAL    = V_TOTAL_DEF,
  parameter int H_SYNC_LEN = H_SYNC_LEN_DEF,
  parameter int V_SYNC_LEN = V_SYNC_LEN_DEF,
  parameter int WIN_X0     = WIN_X0_DEF,
  parameter int WIN_Y0     = WIN_Y0_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iPixelEnable,
  input  logic        iHSync,
  input  logic        iVSync,
  input  logic [2:0]  iColor,
  output logic        oWriteEnable,
  output logic [15:0] oWriteAddress,
  output logic [2:0]  oWriteData,
  output logic        oLocked,
  output logic        oFrameDone,
  output logic        oError
);

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_W    = 10'(H_SYNC_LEN);
  localparam logic [9:0]  V_W    = 10'(V_SYNC_LEN);
  localparam logic [9:0]  X0     = 10'(WIN_X0);
  localparam logic [9:0]  Y0     = 10'(WIN_Y0);
  localparam logic [10:0] X_LO   = 11'(WIN_X0);
  localparam logic [10:0] X_HI   = 11'(WIN_X0 + 255);
  localparam logic [10:0] Y_LO   = 11'(WIN_Y0);
  localparam logic [10:0] Y_HI   = 11'(WIN_Y0 + 255);

  vga_state_t state;

  logic [9:0] col, row;
  logic [9:0] col_n, row_n;
  logic [9:0] h_width, v_width;
  logic [7:0] dx, dy;
  logic       h_rise, v_rise, vpend;
  logic       line_bad, frame_bad, bad;
  logic       in_win;

  vga_sync_meter u_hmeter (
    .clk   (Clock),
    .rst   (Reset),
    .en    (iPixelEnable),
    .tick  (1'b1),
    .sync  (iHSync),
    .rise  (h_rise),
    .width (h_width)
  );

  // Vertical pulse width is counted in lines.
  vga_sync_meter u_vmeter (
    .clk   (Clock),
    .rst   (Reset),
    .en    (iPixelEnable),
    .tick  (h_rise),
    .sync  (iVSync),
    .rise  (v_rise),
    .width (v_width)
  );

  // col/row hold the previous pixel; *_n are this pixel.
  always_comb begin
    col_n = h_rise ? 10'd0 : sat_inc(col);
    row_n = row;
    if (h_rise)
      row_n = (v_rise || vpend) ? 10'd0 : sat_inc(row);
    line_bad  = h_rise &&
                (col != H_LAST || h_width != H_W);
    frame_bad = v_rise &&
                (row != V_LAST || v_width != V_W);
    bad    = line_bad || frame_bad;
    dx     = 8'(col_n - X0);
    dy     = 8'(row_n - Y0);
    in_win = ({1'b0, col_n} >= X_LO) &&
             ({1'b0, col_n} <= X_HI) &&
             ({1'b0, row_n} >= Y_LO) &&
             ({1'b0, row_n} <= Y_HI);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= SEARCH;
      col           <= '0;
      row           <= '0;
      vpend         <= 1'b0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oWriteData    <= '0;
      oFrameDone    <= 1'b0;
      oError        <= 1'b0;
    end else begin
      oWriteEnable <= 1'b0;
      oFrameDone   <= 1'b0;
      if (iPixelEnable) begin
        col   <= col_n;
        row   <= row_n;
        vpend <= !h_rise && (vpend || v_rise);
        unique case (state)
          SEARCH: begin
            if (v_rise)
              state <= ALIGN;
          end
          ALIGN: begin
            if (bad)
              state <= SEARCH;
            else if (v_rise)
              state <= LOCKED;
          end
          LOCKED: begin
            if (bad) begin
              state  <= SEARCH;
              oError <= 1'b1;
            end else begin
              oFrameDone <= v_rise;
              if (in_win) begin
                oWriteEnable  <= 1'b1;
                oWriteAddress <= {dy, dx};
                oWriteData    <= iColor;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign oLocked = (state == LOCKED);

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 16x10 raster
// with a 12x7 capture window at column 4, row 3.
module tb_vga_capture;

  localparam int HT = 16;
  localparam int VT = 10;
  localparam int HS = 3;
  localparam int VS = 2;
  localparam int X0 = 4;
  localparam int Y0 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pe = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [2:0]  color = '0;
  logic        we;
  logic [15:0] addr;
  logic [2:0]  data;
  logic        locked, fd, err;

  int checks = 0;
  int passed = 0;
  int wcount, fdcount, lcount;
  logic        first_seen;
  logic        lock_first;
  logic [15:0] first_addr, last_addr;
  logic [2:0]  first_data, last_data;

  always #5 clk = ~clk;

  vga_capture #(
    .H_TOTAL    (HT),
    .V_TOTAL    (VT),
    .H_SYNC_LEN (HS),
    .V_SYNC_LEN (VS),
    .WIN_X0     (X0),
    .WIN_Y0     (Y0)
  ) dut (
    .Clock         (clk),
    .Reset         (rst),
    .iPixelEnable  (pe),
    .iHSync        (hs),
    .iVSync        (vs),
    .iColor        (color),
    .oWriteEnable  (we),
    .oWriteAddress (addr),
    .oWriteData    (data),
    .oLocked       (locked),
    .oFrameDone    (fd),
    .oError        (err)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},     32'(we),     32'd0);
    check({tag, "_addr"},   32'(addr),   32'd0);
    check({tag, "_data"},   32'(data),   32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_fd"},     32'(fd),     32'd0);
    check({tag, "_err"},    32'(err),    32'd0);
  endtask

  // One pixel: enable high for one clock, then one idle clock.
  task automatic pix(input int r, input int c,
                     input logic h, input logic v,
                     input logic rs);
    logic [15:0] ea;
    @(negedge clk);
    rst = rs;
    pe = 1'b1;
    hs = h;
    vs = v;
    color = 3'(c);
    @(negedge clk);
    pe = 1'b0;
    rst = 1'b0;
    ea = {8'(r - Y0), 8'(c - X0)};
    if (we) begin
      wcount++;
      if (!first_seen) begin
        first_addr = addr;
        first_data = data;
        first_seen = 1'b1;
      end
      last_addr = addr;
      last_data = data;
      check("wr_addr", 32'(addr), 32'(ea));
      check("wr_data", 32'(data), 32'(c % 8));
    end
    if (fd) fdcount++;
    if (locked) lcount++;
  endtask

  task automatic gap();
    repeat (10) begin
      @(negedge clk);
      check("gap_we", 32'(we), 32'd0);
      check("gap_fd", 32'(fd), 32'd0);
    end
  endtask

  task automatic send_frame(input int vlen,
                            input int short_row,
                            input int gap_row,
                            input int gap_col,
                            input int rst_row,
                            input int rst_col);
    int len;
    wcount = 0;
    fdcount = 0;
    lcount = 0;
    first_seen = 1'b0;
    for (int r = 0; r < VT; r++) begin
      len = (r == short_row) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        if (r == gap_row && c == gap_col) gap();
        pix(r, c, c < HS, r < vlen,
            r == rst_row && c == rst_col);
        if (r == 0 && c == 0) lock_first = locked;
        if (r == rst_row && c == rst_col)
          check_zero("midrst");
        if (short_row >= 0 && r == short_row + 1 && c == 0) begin
          check("short_err", 32'(err), 32'd1);
          check("short_locked", 32'(locked), 32'd0);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // A: SEARCH -> ALIGN
    send_frame(VS, -1, -1, -1, -1, -1);
    check("a_lock_first", 32'(lock_first), 32'd0);
    check("a_writes", 32'(wcount), 32'd0);
    check("a_locked", 32'(locked), 32'd0);

    // B: lock at frame start, full window
    send_frame(VS, -1, -1, -1, -1, -1);
    check("b_lock_first", 32'(lock_first), 32'd1);
    check("b_writes", 32'(wcount), 32'd84);
    check("b_fd", 32'(fdcount), 32'd0);
    check("b_first_addr", 32'(first_addr), 32'h0000);
    check("b_first_data", 32'(first_data), 32'd4);
    check("b_last_addr", 32'(last_addr), 32'h060B);
    check("b_last_data", 32'(last_data), 32'd7);

    // C: enable gap mid-window
    send_frame(VS, -1, 5, 8, -1, -1);
    check("c_writes", 32'(wcount), 32'd84);
    check("c_fd", 32'(fdcount), 32'd1);
    check("c_locked", 32'(locked), 32'd1);

    // D: row 5 one pixel short
    send_frame(VS, 5, -1, -1, -1, -1);
    check("d_writes", 32'(wcount), 32'd35);
    check("d_err", 32'(err), 32'd1);
    check("d_locked", 32'(locked), 32'd0);

    // E, F: reacquire
    send_frame(VS, -1, -1, -1, -1, -1);
    check("e_writes", 32'(wcount), 32'd0);
    check("e_lcount", 32'(lcount), 32'd0);
    check("e_err", 32'(err), 32'd1);
    send_frame(VS, -1, -1, -1, -1, -1);
    check("f_lock_first", 32'(lock_first), 32'd1);
    check("f_writes", 32'(wcount), 32'd84);
    check("f_err", 32'(err), 32'd1);

    // G: reset at row 6, col 8
    send_frame(VS, -1, -1, -1, 6, 8);
    check("g_writes", 32'(wcount), 32'd40);
    check("g_locked", 32'(locked), 32'd0);

    // H, I: full good frame before relock
    send_frame(VS, -1, -1, -1, -1, -1);
    check("h_lcount", 32'(lcount), 32'd0);
    check("h_writes", 32'(wcount), 32'd0);
    send_frame(VS, -1, -1, -1, -1, -1);
    check("i_lock_first", 32'(lock_first), 32'd1);
    check("i_writes", 32'(wcount), 32'd84);
    check("i_err", 32'(err), 32'd0);

    // 3-line VSync from a clean reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("v3_reset_locked", 32'(locked), 32'd0);
    for (int f = 0; f < 4; f++) begin
      send_frame(3, -1, -1, -1, -1, -1);
      check("v3_lcount", 32'(lcount), 32'd0);
      check("v3_fd", 32'(fdcount), 32'd0);
      check("v3_writes", 32'(wcount), 32'd0);
    end
    check("v3_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
